// File: rtl/l_port_alloc_ctrl.sv
// Local-port packet allocator: round-robin over N/S/W/E requests for LOCAL, grant locked to tail.
// Latency: grant registered 1 cycle after request; flit_fire_o combinational from winner valid/ready.
// Backpressure: l_ready_i low holds the packet; a silent winner for MAX_STALL cycles is aborted.
module l_port_alloc_ctrl #(
  parameter int               ADDR_W     = 3,
  parameter logic [ADDR_W-1:0] LOCAL_ADDR = 3'b100,
  parameter int               MAX_STALL  = 8,
  parameter int               CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] n_nexthop_addr_i,
  input  logic [ADDR_W-1:0] s_nexthop_addr_i,
  input  logic [ADDR_W-1:0] w_nexthop_addr_i,
  input  logic [ADDR_W-1:0] e_nexthop_addr_i,
  input  logic              n_valid_i,
  input  logic              s_valid_i,
  input  logic              w_valid_i,
  input  logic              e_valid_i,
  input  logic              n_tail_i,
  input  logic              s_tail_i,
  input  logic              w_tail_i,
  input  logic              e_tail_i,
  input  logic              l_ready_i,
  output logic              grant_n_o,
  output logic              grant_s_o,
  output logic              grant_w_o,
  output logic              grant_e_o,
  output logic [2:0]        xbar_sel_o,
  output logic              flit_fire_o,
  output logic              change_order_o,
  output logic              abort_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  pkt_count_o
);

  localparam int SC_W = $clog2(MAX_STALL + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      req;
  logic [3:0]      valid_vec;
  logic [3:0]      tail_vec;
  logic [3:0]      grant_vec;
  logic [1:0]      ptr;
  logic [1:0]      win_idx;
  logic [1:0]      pick_idx;
  logic            pick_vld;
  logic            win_valid;
  logic            win_tail;
  logic            rel_tail;
  logic            rel_abort;
  logic [SC_W-1:0] stall_cnt;

  // Index 0..3 = N, S, W, E throughout.
  assign valid_vec = {e_valid_i, w_valid_i, s_valid_i, n_valid_i};
  assign tail_vec  = {e_tail_i, w_tail_i, s_tail_i, n_tail_i};
  assign req = valid_vec & {e_nexthop_addr_i == LOCAL_ADDR, w_nexthop_addr_i == LOCAL_ADDR,
                            s_nexthop_addr_i == LOCAL_ADDR, n_nexthop_addr_i == LOCAL_ADDR};

  // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = XFER;
      XFER:    if (rel_tail || rel_abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_valid   = valid_vec[win_idx];
    win_tail    = tail_vec[win_idx];
    flit_fire_o = (state == XFER) & win_valid & l_ready_i;
    rel_tail    = flit_fire_o & win_tail;
    rel_abort   = (state == XFER) & ~win_valid & (stall_cnt == SC_W'(MAX_STALL - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_vec      <= 4'b0000;
      win_idx        <= 2'd0;
      xbar_sel_o     <= 3'b111;
      ptr            <= 2'd0;
      change_order_o <= 1'b0;
      abort_o        <= 1'b0;
      pkt_count_o    <= '0;
      stall_cnt      <= '0;
    end else begin
      change_order_o <= 1'b0;
      abort_o        <= 1'b0;
      if (state == IDLE && pick_vld) begin
        grant_vec  <= 4'b0001 << pick_idx;
        win_idx    <= pick_idx;
        xbar_sel_o <= {1'b0, pick_idx};
        stall_cnt  <= '0;
      end else if (rel_tail || rel_abort) begin
        grant_vec      <= 4'b0000;
        xbar_sel_o     <= 3'b111;
        ptr            <= win_idx + 2'd1;
        change_order_o <= 1'b1;
        abort_o        <= rel_abort;
        stall_cnt      <= '0;
        if (rel_tail) pkt_count_o <= pkt_count_o + CNT_W'(1);
      end else if (state == XFER) begin
        // Only a missing flit counts toward the stall limit; sink backpressure does not.
        if (win_valid) stall_cnt <= '0;
        else           stall_cnt <= stall_cnt + SC_W'(1);
      end
    end
  end

  assign grant_n_o = grant_vec[0];
  assign grant_s_o = grant_vec[1];
  assign grant_w_o = grant_vec[2];
  assign grant_e_o = grant_vec[3];
  assign busy_o    = (state == XFER);

endmodule

// File: tb/tb_l_port_alloc_ctrl.sv
// Directed bench for l_port_alloc_ctrl with hand-computed expectations.
module tb_l_port_alloc_ctrl;

  localparam logic [2:0] LOC = 3'b100;

  logic        clk;
  logic        reset;
  logic [2:0]  n_addr, s_addr, w_addr, e_addr;
  logic        n_vld, s_vld, w_vld, e_vld;
  logic        n_tail, s_tail, w_tail, e_tail;
  logic        l_ready;
  logic        grant_n, grant_s, grant_w, grant_e;
  logic [2:0]  xbar_sel;
  logic        flit_fire, change_order, abort, busy;
  logic [15:0] pkt_count;
  wire  [3:0]  gv = {grant_e, grant_w, grant_s, grant_n};

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_order [5];

  l_port_alloc_ctrl dut (
    .clk(clk), .reset(reset),
    .n_nexthop_addr_i(n_addr), .s_nexthop_addr_i(s_addr),
    .w_nexthop_addr_i(w_addr), .e_nexthop_addr_i(e_addr),
    .n_valid_i(n_vld), .s_valid_i(s_vld), .w_valid_i(w_vld), .e_valid_i(e_vld),
    .n_tail_i(n_tail), .s_tail_i(s_tail), .w_tail_i(w_tail), .e_tail_i(e_tail),
    .l_ready_i(l_ready),
    .grant_n_o(grant_n), .grant_s_o(grant_s), .grant_w_o(grant_w), .grant_e_o(grant_e),
    .xbar_sel_o(xbar_sel), .flit_fire_o(flit_fire), .change_order_o(change_order),
    .abort_o(abort), .busy_o(busy), .pkt_count_o(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_vld = 0; s_vld = 0; w_vld = 0; e_vld = 0;
    n_tail = 0; s_tail = 0; w_tail = 0; e_tail = 0;
    n_addr = 0; s_addr = 0; w_addr = 0; e_addr = 0;
    l_ready = 1;
  endtask

  initial begin
    int fires;
    logic [3:0] head_sent;
    logic       prev_busy;
    logic [2:0] order[$];

    exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    clr();
    reset = 0;
    tick();
    chk("rst_grant", gv, 0);
    chk("rst_sel", xbar_sel, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_co", change_order, 0);
    chk("rst_abort", abort, 0);
    chk("rst_fire", flit_fire, 0);
    tick();
    reset = 1;

    // T5: non-local next hop is never granted
    n_vld = 1; n_addr = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_grant", gv, 0);
      chk("t5_sel", xbar_sel, 3'b111);
      chk("t5_busy", busy, 0);
    end
    clr();
    tick();

    // T2: N and E single-flit packets, ptr=0
    n_vld = 1; n_addr = LOC; n_tail = 1;
    e_vld = 1; e_addr = LOC; e_tail = 1;
    tick();
    chk("t2_grant_n", gv, 4'b0001);
    chk("t2_sel_n", xbar_sel, 0);
    chk("t2_busy", busy, 1);
    chk("t2_fire_n", flit_fire, 1);
    tick();
    n_vld = 0; n_tail = 0;
    chk("t2_rel_n", gv, 0);
    chk("t2_co_n", change_order, 1);
    chk("t2_sel_idle", xbar_sel, 3'b111);
    chk("t2_pkt1", pkt_count, 1);
    tick();
    chk("t2_grant_e", gv, 4'b1000);
    chk("t2_sel_e", xbar_sel, 3);
    chk("t2_co_off", change_order, 0);
    chk("t2_fire_e", flit_fire, 1);
    tick();
    clr();
    chk("t2_co_e", change_order, 1);
    chk("t2_pkt2", pkt_count, 2);

    // T3: W 3-flit packet with sink backpressure on flit 2
    w_vld = 1; w_addr = LOC;
    tick();
    chk("t3_grant", gv, 4'b0100);
    chk("t3_sel", xbar_sel, 2);
    w_addr = 3'b001;
    fires = 0;
    #1 fires += int'(flit_fire);
    tick();
    l_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 fires += int'(flit_fire);
      tick();
      chk("t3_hold", gv, 4'b0100);
      chk("t3_no_abort", abort, 0);
    end
    l_ready = 1;
    #1 fires += int'(flit_fire);
    tick();
    w_tail = 1;
    #1 fires += int'(flit_fire);
    tick();
    clr();
    chk("t3_fires", fires, 3);
    chk("t3_rel", gv, 0);
    chk("t3_co", change_order, 1);
    chk("t3_abort", abort, 0);
    chk("t3_pkt", pkt_count, 3);

    // T4: S granted then starves for MAX_STALL cycles
    s_vld = 1; s_addr = LOC;
    tick();
    chk("t4_grant", gv, 4'b0010);
    chk("t4_sel", xbar_sel, 1);
    tick();
    s_vld = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_pre_abort", abort, 0);
      chk("t4_hold", gv, 4'b0010);
    end
    tick();
    chk("t4_abort", abort, 1);
    chk("t4_co", change_order, 1);
    chk("t4_rel", gv, 0);
    chk("t4_pkt", pkt_count, 3);
    // ptr should now be 2: W beats S
    s_vld = 1; s_addr = LOC; s_tail = 1;
    w_vld = 1; w_addr = LOC; w_tail = 1;
    tick();
    chk("t4_ptr_w", gv, 4'b0100);
    chk("t4_abort_off", abort, 0);
    tick();
    clr();
    chk("t4_pkt_w", pkt_count, 4);

    // T1: reset in the middle of a packet
    n_vld = 1; n_addr = LOC;
    tick();
    chk("t1_grant", gv, 4'b0001);
    tick();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_grant0", gv, 0);
      chk("t1_sel", xbar_sel, 3'b111);
      chk("t1_pkt", pkt_count, 0);
      chk("t1_busy", busy, 0);
      chk("t1_co", change_order, 0);
    end
    reset = 1;
    clr();
    tick();
    chk("t1_idle", busy, 0);

    // T6: all four streaming 2-flit packets
    n_vld = 1; s_vld = 1; w_vld = 1; e_vld = 1;
    n_addr = LOC; s_addr = LOC; w_addr = LOC; e_addr = LOC;
    head_sent = 4'b0000;
    prev_busy = 0;
    for (int i = 0; i < 16; i++) begin
      {e_tail, w_tail, s_tail, n_tail} = head_sent;
      #1;
      if (flit_fire) head_sent[xbar_sel[1:0]] = ~head_sent[xbar_sel[1:0]];
      tick();
      chk("t6_onehot", 32'($onehot0(gv)), 1);
      if (busy && !prev_busy) order.push_back(xbar_sel);
      prev_busy = busy;
    end
    chk("t6_count", 32'(order.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk($sformatf("t6_order%0d", k), order[k], exp_order[k]);
    chk("t6_pkt", pkt_count, 5);
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
